// File: rtl/histogram_hesaplama_pkg.sv
// Shared constants and FSM encoding for the histogram accumulation block.
package hist_pkg;
  localparam int PIX_W           = 8;
  localparam int NUM_BINS        = 1 << PIX_W;
  localparam int BIN_W_DEF       = 24;
  localparam int PIXEL_COUNT_DEF = 76800;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_ACCUM = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_OUT   = 3'd4;
endpackage

// File: rtl/histogram_hesaplama_if.sv
// Pixel-in and bin-out valid/ready streams of the histogram block.
interface histogram_hesaplama_if #(
  parameter int PIX_W = 8,
  parameter int BIN_W = 24
);
  logic [PIX_W-1:0] pix_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  logic [BIN_W-1:0] bin_o;
  logic [PIX_W-1:0] bin_idx_o;
  logic             bin_valid_o;
  logic             bin_ready_i;

  modport slave (
    input  pix_i, pix_valid_i, bin_ready_i,
    output pix_ready_o, bin_o, bin_idx_o, bin_valid_o
  );

  modport master (
    output pix_i, pix_valid_i, bin_ready_i,
    input  pix_ready_o, bin_o, bin_idx_o, bin_valid_o
  );
endinterface

// File: rtl/histogram_hesaplama_bin_ram.sv
// Bin storage: simple dual-port RAM, one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module hist_bin_ram #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk_i) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/histogram_hesaplama.sv
// Counts one frame of grey-level pixels into 256 bins, then streams the bins
// out in index order. Bins are updated through a 2-stage read-modify-write.
module histogram_hesaplama #(
  parameter int PIXEL_COUNT = hist_pkg::PIXEL_COUNT_DEF,
  parameter int BIN_W       = hist_pkg::BIN_W_DEF,
  parameter int PIX_W       = hist_pkg::PIX_W
) (
  input  logic clk_i,
  input  logic rest_i,
  input  logic en_i,
  input  logic start_i,
  histogram_hesaplama_if.slave bus,
  output logic busy_o,
  output logic done_o,
  output logic sat_o
);
  import hist_pkg::*;

  localparam int PCW = $clog2(PIXEL_COUNT + 1);
  localparam logic [PCW-1:0]   PIX_LAST = PCW'(PIXEL_COUNT - 1);
  localparam logic [PIX_W-1:0] BIN_LAST = PIX_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0] BIN_MAX  = '1;

  state_t           state_q;
  logic [PCW-1:0]   pix_cnt;
  logic [PIX_W:0]   idx_q;      // clear address, then output read address (MSB = all issued)
  logic             done_q, sat_q;

  // RMW pipeline: stage 1 = handshake/read, stage 2 = increment/write
  logic             pix_hs;
  logic             s2_v;
  logic [PIX_W-1:0] s2_addr;
  logic             fwd_q;
  logic [BIN_W-1:0] fwd_data;
  logic [BIN_W-1:0] old_val, inc_val;
  logic             at_max;

  logic             ram_we, ram_re;
  logic [PIX_W-1:0] ram_wa, ram_ra;
  logic [BIN_W-1:0] ram_wd, ram_rd;

  // output path: RAM read stage followed by the output register
  logic             rd_v;
  logic [PIX_W-1:0] rd_idx;
  logic             out_v;
  logic [BIN_W-1:0] bin_q;
  logic [PIX_W-1:0] bin_idx_q;
  logic             out_adv, rd_adv, issue, bin_hs;

  assign pix_hs  = en_i && bus.pix_valid_i && (state_q == ST_ACCUM);
  assign old_val = fwd_q ? fwd_data : ram_rd;
  assign at_max  = (old_val == BIN_MAX);
  assign inc_val = at_max ? old_val : old_val + 1'b1;

  assign bin_hs  = en_i && out_v && bus.bin_ready_i;
  assign out_adv = !out_v || bus.bin_ready_i;
  assign rd_adv  = !rd_v || out_adv;
  assign issue   = (state_q == ST_OUT) && !idx_q[PIX_W] && rd_adv;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = s2_addr;
    ram_wd = inc_val;
    if (state_q == ST_CLEAR) begin
      ram_we = en_i;
      ram_wa = idx_q[PIX_W-1:0];
      ram_wd = '0;
    end else if (s2_v) begin
      ram_we = en_i;
    end
    ram_re = en_i && ((state_q == ST_OUT) ? rd_adv : pix_hs);
    ram_ra = (state_q == ST_OUT) ? idx_q[PIX_W-1:0] : bus.pix_i;
  end

  hist_bin_ram #(.AW(PIX_W), .DW(BIN_W)) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .wa    (ram_wa),
    .wd    (ram_wd),
    .re    (ram_re),
    .ra    (ram_ra),
    .rd    (ram_rd)
  );

  always_ff @(posedge clk_i or negedge rest_i) begin
    if (!rest_i) begin
      state_q   <= ST_IDLE;
      pix_cnt   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      s2_v      <= 1'b0;
      s2_addr   <= '0;
      fwd_q     <= 1'b0;
      fwd_data  <= '0;
      rd_v      <= 1'b0;
      rd_idx    <= '0;
      out_v     <= 1'b0;
      bin_q     <= '0;
      bin_idx_q <= '0;
    end else if (en_i) begin
      done_q <= 1'b0;
      s2_v   <= pix_hs;
      if (pix_hs) begin
        s2_addr  <= bus.pix_i;
        // the write in flight this cycle is invisible to the read just issued
        fwd_q    <= ram_we && (ram_wa == bus.pix_i);
        fwd_data <= inc_val;
      end
      if (s2_v && at_max) sat_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            sat_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (idx_q[PIX_W-1:0] == BIN_LAST) begin
            idx_q   <= '0;
            pix_cnt <= '0;
            state_q <= ST_ACCUM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_ACCUM: begin
          if (pix_hs) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PIX_LAST) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          idx_q   <= '0;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (issue) idx_q <= idx_q + 1'b1;
          if (bin_hs && (bin_idx_q == BIN_LAST)) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (rd_adv) begin
        rd_v   <= issue;
        rd_idx <= idx_q[PIX_W-1:0];
      end
      if (out_adv) begin
        out_v <= rd_v;
        if (rd_v) begin
          bin_q     <= ram_rd;
          bin_idx_q <= rd_idx;
        end
      end
    end
  end

  assign bus.pix_ready_o = (state_q == ST_ACCUM);
  assign bus.bin_o       = bin_q;
  assign bus.bin_idx_o   = bin_idx_q;
  assign bus.bin_valid_o = out_v;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign sat_o           = sat_q;
endmodule
